// File: rtl/id_ex_register_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-bundle layout,
// bundle width and the hard-wired zero register specifier.
package id_ex_register_pkg;

    // Width of the opaque EX/MEM/WB control bundle carried through ID/EX.
    localparam int CTRL_W = 12;

    // Bit positions inside the control bundle (bits 9..11 are spare).
    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEMWRITE  = 1;
    localparam int CTRL_MEMTOREG  = 2;
    localparam int CTRL_ALUSRC    = 3;
    localparam int CTRL_ALUOP_LSB = 4;
    localparam int CTRL_ALUOP_W   = 4;
    localparam int CTRL_REGDST    = 8;

    // $zero can never carry a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when the EX destination matches a source and is not $zero.
    function automatic logic reg_depends(input logic [4:0] ex_dst, input logic [4:0] id_src);
        return (ex_dst != REG_ZERO) && (ex_dst == id_src);
    endfunction

endpackage

// File: rtl/id_ex_register_load_use_detect.sv
// Combinational load-use comparator: raises a hazard when a valid load in EX
// writes a register that the valid instruction in ID reads.
module id_ex_register_load_use_detect
    import id_ex_register_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       stall,
    input  logic       flush,
    output logic       hazard
);

    logic load_in_ex;
    logic src_match;

    // Hazard request; suppressed while the register is frozen or squashing,
    // since neither of those edges would capture the dependent instruction.
    always_comb begin
        load_in_ex = ex_valid && ex_mem_read;
        src_match  = reg_depends(ex_rt, id_rs) ||
                     (id_uses_rt && reg_depends(ex_rt, id_rt));
        hazard     = load_in_ex && id_valid && src_match && !stall && !flush;
    end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register of the five-stage MIPS datapath. Captures decode
// outputs for EX one cycle later, inserts a bubble on load-use hazards, obeys
// downstream stall and branch flush, and counts bubbles with saturation.
// EX_Valid qualifies the entry: when it is 0 the entry is a bubble and
// EX_MemRead / EX_Ctrl are guaranteed 0 so no side effect can escape.
module id_ex_register #(
    parameter int CTRL_W = id_ex_register_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              ID_Valid,
    input  logic [31:0]       ID_PCPlus4,
    input  logic [31:0]       ID_ReadData1,
    input  logic [31:0]       ID_ReadData2,
    input  logic [31:0]       ID_ImmExt,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic [4:0]        ID_Rd,
    input  logic              ID_UsesRt,
    input  logic              ID_MemRead,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    output logic              EX_Valid,
    output logic [31:0]       EX_PCPlus4,
    output logic [31:0]       EX_ReadData1,
    output logic [31:0]       EX_ReadData2,
    output logic [31:0]       EX_ImmExt,
    output logic [4:0]        EX_Rs,
    output logic [4:0]        EX_Rt,
    output logic [4:0]        EX_Rd,
    output logic              EX_MemRead,
    output logic [CTRL_W-1:0] EX_Ctrl,
    output logic              HazardStall,
    output logic [CNT_W-1:0]  BubbleCount
);

    logic              valid_q, valid_d;
    logic [31:0]       pc_plus4_q, pc_plus4_d;
    logic [31:0]       read_data1_q, read_data1_d;
    logic [31:0]       read_data2_q, read_data2_d;
    logic [31:0]       imm_ext_q, imm_ext_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;
    logic              mem_read_q, mem_read_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  bubble_count_q, bubble_count_d;

    logic hazard;
    logic bubble;

    id_ex_register_load_use_detect u_load_use_detect (
        .ex_valid    (valid_q),
        .ex_mem_read (mem_read_q),
        .ex_rt       (rt_q),
        .id_valid    (ID_Valid),
        .id_rs       (ID_Rs),
        .id_rt       (ID_Rt),
        .id_uses_rt  (ID_UsesRt),
        .stall       (Stall),
        .flush       (Flush),
        .hazard      (hazard)
    );

    // Next-state selection: stall holds, flush or hazard bubbles, else load.
    always_comb begin
        valid_d        = valid_q;
        pc_plus4_d     = pc_plus4_q;
        read_data1_d   = read_data1_q;
        read_data2_d   = read_data2_q;
        imm_ext_d      = imm_ext_q;
        rs_d           = rs_q;
        rt_d           = rt_q;
        rd_d           = rd_q;
        mem_read_d     = mem_read_q;
        ctrl_d         = ctrl_q;
        bubble_count_d = bubble_count_q;
        // Hazard is already masked by Flush, so a coincident flush and
        // hazard form a single bubble and a single count.
        bubble         = Flush || hazard;

        if (!Stall) begin
            // Data fields load on every non-stalled edge; in a bubble they
            // are don't-care because the entry is marked invalid.
            pc_plus4_d   = ID_PCPlus4;
            read_data1_d = ID_ReadData1;
            read_data2_d = ID_ReadData2;
            imm_ext_d    = ID_ImmExt;
            rs_d         = ID_Rs;
            rt_d         = ID_Rt;
            rd_d         = ID_Rd;

            if (bubble) begin
                valid_d    = 1'b0;
                mem_read_d = 1'b0;
                ctrl_d     = '0;
                if (bubble_count_q != {CNT_W{1'b1}}) begin
                    bubble_count_d = bubble_count_q + CNT_W'(1);
                end
            end else begin
                valid_d    = ID_Valid;
                mem_read_d = ID_Valid && ID_MemRead;
                ctrl_d     = ID_Valid ? ID_Ctrl : '0;
            end
        end
    end

    // Pipeline state with asynchronous clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid_q        <= 1'b0;
            pc_plus4_q     <= '0;
            read_data1_q   <= '0;
            read_data2_q   <= '0;
            imm_ext_q      <= '0;
            rs_q           <= '0;
            rt_q           <= '0;
            rd_q           <= '0;
            mem_read_q     <= 1'b0;
            ctrl_q         <= '0;
            bubble_count_q <= '0;
        end else begin
            valid_q        <= valid_d;
            pc_plus4_q     <= pc_plus4_d;
            read_data1_q   <= read_data1_d;
            read_data2_q   <= read_data2_d;
            imm_ext_q      <= imm_ext_d;
            rs_q           <= rs_d;
            rt_q           <= rt_d;
            rd_q           <= rd_d;
            mem_read_q     <= mem_read_d;
            ctrl_q         <= ctrl_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    // Output drive.
    always_comb begin
        EX_Valid     = valid_q;
        EX_PCPlus4   = pc_plus4_q;
        EX_ReadData1 = read_data1_q;
        EX_ReadData2 = read_data2_q;
        EX_ImmExt    = imm_ext_q;
        EX_Rs        = rs_q;
        EX_Rt        = rt_q;
        EX_Rd        = rd_q;
        EX_MemRead   = mem_read_q;
        EX_Ctrl      = ctrl_q;
        HazardStall  = hazard;
        BubbleCount  = bubble_count_q;
    end

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: a table of single-edge vectors with expected
// EX outputs, plus hand sequences for async reset and counter saturation.
module tb_id_ex_register;

    localparam int OW = 173;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        Flush;
    logic        ID_Valid;
    logic [31:0] ID_PCPlus4, ID_ReadData1, ID_ReadData2, ID_ImmExt;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
    logic        ID_UsesRt, ID_MemRead;
    logic [11:0] ID_Ctrl;
    logic        EX_Valid;
    logic [31:0] EX_PCPlus4, EX_ReadData1, EX_ReadData2, EX_ImmExt;
    logic [4:0]  EX_Rs, EX_Rt, EX_Rd;
    logic        EX_MemRead;
    logic [11:0] EX_Ctrl;
    logic        HazardStall;
    logic [15:0] BubbleCount;

    id_ex_register #(.CTRL_W(12), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .ID_Valid(ID_Valid), .ID_PCPlus4(ID_PCPlus4),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
        .ID_ImmExt(ID_ImmExt), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_UsesRt(ID_UsesRt), .ID_MemRead(ID_MemRead), .ID_Ctrl(ID_Ctrl),
        .EX_Valid(EX_Valid), .EX_PCPlus4(EX_PCPlus4),
        .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
        .EX_ImmExt(EX_ImmExt), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
        .EX_MemRead(EX_MemRead), .EX_Ctrl(EX_Ctrl),
        .HazardStall(HazardStall), .BubbleCount(BubbleCount)
    );

    // Clock.
    always #5 Clk = ~Clk;

    typedef struct {
        logic        stall, flush, id_valid;
        logic [4:0]  rs, rt, rd;
        logic        uses_rt, mem_read;
        logic [11:0] ctrl;
        logic [31:0] imm;
        logic        exp_hazard, exp_valid, exp_mem_read;
        logic [11:0] exp_ctrl;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[21];

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] msk_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference copy of the data fields most recently captured.
    logic [31:0] m_pc, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;

    function automatic logic [OW-1:0] pack_out(
        input logic v, input logic [31:0] pc, input logic [31:0] r1,
        input logic [31:0] r2, input logic [31:0] im, input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd, input logic mr,
        input logic [11:0] c, input logic [15:0] n);
        return {v, pc, r1, r2, im, rs, rt, rd, mr, c, n};
    endfunction

    function automatic vec_t mkv(
        input logic s, input logic f, input logic v, input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd, input logic ur,
        input logic mr, input logic [11:0] c, input logic [31:0] im,
        input logic eh, input logic ev, input logic emr,
        input logic [11:0] ec, input logic [15:0] en);
        vec_t t;
        t.stall = s; t.flush = f; t.id_valid = v;
        t.rs = rs; t.rt = rt; t.rd = rd; t.uses_rt = ur; t.mem_read = mr;
        t.ctrl = c; t.imm = im;
        t.exp_hazard = eh; t.exp_valid = ev; t.exp_mem_read = emr;
        t.exp_ctrl = ec; t.exp_cnt = en;
        return t;
    endfunction

    function automatic logic [OW-1:0] dut_out();
        return pack_out(EX_Valid, EX_PCPlus4, EX_ReadData1, EX_ReadData2,
                        EX_ImmExt, EX_Rs, EX_Rt, EX_Rd, EX_MemRead,
                        EX_Ctrl, BubbleCount);
    endfunction

    task automatic check_val(input string name, input logic [OW-1:0] act,
                             input logic [OW-1:0] exp, input logic [OW-1:0] msk);
        n_cmp++;
        if ((act & msk) !== (exp & msk)) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act & msk, exp & msk);
        end
    endtask

    // Driver + scoreboard for one vector: drive at negedge, check the
    // combinational hazard, push the expected EX state, pop it after the edge.
    task automatic apply_vec(input string name, input vec_t v);
        logic [OW-1:0] e, m, bub_mask;
        @(negedge Clk);
        Stall = v.stall; Flush = v.flush; ID_Valid = v.id_valid;
        ID_Rs = v.rs; ID_Rt = v.rt; ID_Rd = v.rd;
        ID_UsesRt = v.uses_rt; ID_MemRead = v.mem_read; ID_Ctrl = v.ctrl;
        ID_ImmExt = v.imm;
        ID_PCPlus4 = $urandom; ID_ReadData1 = $urandom; ID_ReadData2 = $urandom;
        #1;
        check_val({name, "_hazard"}, OW'(HazardStall), OW'(v.exp_hazard), '1);
        if (!v.stall) begin
            m_pc = ID_PCPlus4; m_rd1 = ID_ReadData1; m_rd2 = ID_ReadData2;
            m_imm = ID_ImmExt; m_rs = ID_Rs; m_rt = ID_Rt; m_rd = ID_Rd;
        end
        e = pack_out(v.exp_valid, m_pc, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd,
                     v.exp_mem_read, v.exp_ctrl, v.exp_cnt);
        bub_mask = pack_out(1'b1, '0, '0, '0, '0, '0, '0, '0, 1'b1, '1, '1);
        m = (v.exp_valid || v.stall) ? '1 : bub_mask;
        exp_q.push_back(e);
        msk_q.push_back(m);
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        check_val({name, "_ex"}, dut_out(), e, m);
    endtask

    initial begin
        // Reset and idle inputs.
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; ID_Valid = 1'b0;
        ID_PCPlus4 = '0; ID_ReadData1 = '0; ID_ReadData2 = '0; ID_ImmExt = '0;
        ID_Rs = '0; ID_Rt = '0; ID_Rd = '0; ID_UsesRt = 1'b0;
        ID_MemRead = 1'b0; ID_Ctrl = '0;
        m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_rd = '0;

        //               s f v rs  rt  rd ur mr ctrl     imm           eh ev emr ectrl   ecnt
        vecs[0]  = mkv(0,0,1, 3,  4,  5, 1,0, 12'hABC, 32'hFFFF8000, 0, 1,0, 12'hABC, 0);
        vecs[1]  = mkv(0,0,1, 1,  8,  0, 0,1, 12'h015, $urandom,     0, 1,1, 12'h015, 0);
        vecs[2]  = mkv(0,0,1, 8,  2,  6, 1,0, 12'h101, $urandom,     1, 0,0, 12'h000, 1);
        vecs[3]  = mkv(0,0,1, 8,  2,  6, 1,0, 12'h101, $urandom,     0, 1,0, 12'h101, 1);
        vecs[4]  = mkv(0,0,1, 1,  0,  0, 0,1, 12'h015, $urandom,     0, 1,1, 12'h015, 1);
        vecs[5]  = mkv(0,0,1, 0,  0,  3, 0,0, 12'h001, $urandom,     0, 1,0, 12'h001, 1);
        vecs[6]  = mkv(0,0,1, 2,  9,  0, 0,1, 12'h015, $urandom,     0, 1,1, 12'h015, 1);
        vecs[7]  = mkv(0,0,1, 1,  9,  4, 0,0, 12'h002, $urandom,     0, 1,0, 12'h002, 1);
        vecs[8]  = mkv(0,0,1, 2, 10,  0, 0,1, 12'h015, $urandom,     0, 1,1, 12'h015, 1);
        vecs[9]  = mkv(1,0,1, 10, 3,  4, 1,0, 12'h0F0, $urandom,     0, 1,1, 12'h015, 1);
        vecs[10] = mkv(0,0,1, 10, 3,  4, 1,0, 12'h0F0, $urandom,     1, 0,0, 12'h000, 2);
        vecs[11] = mkv(0,0,1, 10, 3,  4, 1,0, 12'h0F0, $urandom,     0, 1,0, 12'h0F0, 2);
        vecs[12] = mkv(0,0,1, 2, 11,  0, 0,1, 12'h015, $urandom,     0, 1,1, 12'h015, 2);
        vecs[13] = mkv(0,1,1, 11, 3,  4, 1,0, 12'h0F0, $urandom,     0, 0,0, 12'h000, 3);
        vecs[14] = mkv(0,0,0, 1,  2,  3, 1,1, 12'hFFF, $urandom,     0, 0,0, 12'h000, 3);
        vecs[15] = mkv(0,0,1, 5,  7,  8, 1,0, 12'h3C3, $urandom,     0, 1,0, 12'h3C3, 3);
        vecs[16] = mkv(0,0,1, 2, 12,  0, 0,1, 12'h015, $urandom,     0, 1,1, 12'h015, 3);
        vecs[17] = mkv(0,0,1, 1, 12, 13, 1,0, 12'h111, $urandom,     1, 0,0, 12'h000, 4);
        vecs[18] = mkv(0,0,1, 1, 12, 13, 1,0, 12'h111, $urandom,     0, 1,0, 12'h111, 4);
        vecs[19] = mkv(0,1,1, 4,  5,  6, 1,0, 12'h222, $urandom,     0, 0,0, 12'h000, 5);
        vecs[20] = mkv(0,0,1, 4,  5,  6, 1,1, 12'h555, $urandom,     0, 1,1, 12'h555, 5);

        repeat (2) @(posedge Clk);
        #1;
        check_val("reset_state", dut_out(), '0, '1);
        check_val("reset_hazard", OW'(HazardStall), '0, '1);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            apply_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset between edges: EX_Valid=1, BubbleCount=5 here.
        @(negedge Clk);
        Stall = 1'b0; Flush = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check_val("async_reset_out", dut_out(), '0, '1);
        check_val("async_reset_hazard", OW'(HazardStall), '0, '1);
        @(negedge Clk);
        Reset = 1'b0;
        m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_rd = '0;
        apply_vec("post_reset_load",
                  mkv(0,0,1, 3, 4, 5, 1,1, 12'h0AA, $urandom, 0, 1,1, 12'h0AA, 0));

        // Saturation: bring the counter to FFFE with back-to-back flushes.
        @(negedge Clk);
        Flush = 1'b1; ID_Valid = 1'b1;
        repeat (65534) @(posedge Clk);
        #1;
        check_val("cnt_fffe", OW'(BubbleCount), OW'(16'hFFFE), '1);
        apply_vec("sat_flush1",
                  mkv(0,1,1, 1, 2, 3, 1,0, 12'h010, $urandom, 0, 0,0, 12'h000, 16'hFFFF));
        apply_vec("sat_flush2",
                  mkv(0,1,1, 1, 2, 3, 1,0, 12'h010, $urandom, 0, 0,0, 12'h000, 16'hFFFF));
        apply_vec("sat_load",
                  mkv(0,0,1, 1, 14, 0, 0,1, 12'h015, $urandom, 0, 1,1, 12'h015, 16'hFFFF));
        apply_vec("sat_hazard",
                  mkv(0,0,1, 14, 2, 3, 1,0, 12'h020, $urandom, 1, 0,0, 12'h000, 16'hFFFF));

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register of the five-stage MIPS datapath. It captures the decode-stage outputs: register-file read data, the 32-bit extended immediate from the ID-stage immediate extender, register specifiers and the control bundle. It presents them to the EX stage one cycle later. It also detects load-use hazards, inserts bubbles, honours stall and flush requests, and keeps a saturating bubble counter.

## Interface
- CTRL_W, 12: width of the opaque EX/MEM/WB control bundle.
- CNT_W, 16: width of the bubble performance counter.

- Clk  in  1  pipeline clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Stall  in  1  downstream (EX/MEM) stall; hold all contents.
- Flush  in  1  branch/jump flush; squash the entry being captured.
- ID_Valid  in  1  the ID stage holds a real instruction.
- ID_PCPlus4  in  32  PC+4 of the ID instruction.
- ID_ReadData1, ID_ReadData2  in  32 each  register-file read ports.
- ID_ImmExt  in  32  extended immediate (sign- or zero-extended per ExtendSign).
- ID_Rs, ID_Rt, ID_Rd  in  5 each  register specifiers.
- ID_UsesRt  in  1  the ID instruction reads Rt as a source.
- ID_MemRead  in  1  the ID instruction is a load.
- ID_Ctrl  in  CTRL_W  remaining control bundle.
- EX_Valid  out  1  the EX entry is a real instruction.
- EX_PCPlus4, EX_ReadData1, EX_ReadData2, EX_ImmExt  out  32 each  registered copies of the ID inputs.
- EX_Rs, EX_Rt, EX_Rd  out  5 each  registered copies.
- EX_MemRead  out  1  registered copy; forced to 0 when the entry is invalid.
- EX_Ctrl  out  CTRL_W  registered copy; forced to all-zero when the entry is invalid.
- HazardStall  out  1  combinational request to freeze PC and IF/ID.
- BubbleCount  out  CNT_W  saturating count of bubbles inserted.

## Operation
- **Hazard condition.** HazardStall = EX_Valid & EX_MemRead & (EX_Rt != 0) & ID_Valid & ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt))).
  - HazardStall is forced to 0 while Stall or Flush is asserted.
- **Per-edge priority**, highest first:
  1. **Reset:** every output register is cleared to 0, including EX_Valid and BubbleCount.
  2. **Stall:** all registers hold; BubbleCount holds.
  3. **Flush:** EX_Valid←0, EX_MemRead←0, EX_Ctrl←0; data fields load normally (don't-care); BubbleCount increments.
  4. **HazardStall:** bubble. EX_Valid←0, EX_MemRead←0, EX_Ctrl←0; BubbleCount increments. Upstream holds the ID instruction, so it is re-presented next cycle.
  5. **Otherwise:** load every field. EX_Valid←ID_Valid; EX_MemRead and EX_Ctrl are gated by ID_Valid.
- **Invalid entries.** Whenever EX_Valid=0, EX_MemRead and EX_Ctrl read 0. This guarantees no memory or register write from a bubble.
- **ID_ImmExt** passes through unmodified. No re-extension or width change happens in this block.
- **BubbleCount** saturates at 2^CNT_W−1 and never wraps.

## Timing
- Latency is 1 cycle, ID to EX.
- HazardStall is combinational from EX registers plus ID inputs. It is valid in the same cycle the ID instruction is presented.
- A load followed by a dependent instruction yields exactly one bubble. On the next edge EX_Valid=0, so HazardStall deasserts and the dependent instruction loads on the following edge.
- **Stall and hazard together:** Stall wins. Nothing changes, and HazardStall re-evaluates after Stall drops.
- **Flush and hazard together:** Flush wins. One bubble is counted, not two.
- **Reset mid-stall or mid-bubble:** outputs clear immediately (asynchronous). The first post-reset edge behaves as a normal load.
- Rt=0 never triggers a hazard.

## Structure
- The shared package holds:
  - control-bundle bit positions (RegWrite, MemWrite, MemToReg, ALUSrc, ALUOp, RegDst);
  - CTRL_W;
  - REG_ZERO = 5'd0.
- One natural sub-module is `load_use_detect`, the purely combinational hazard comparator. The register file and counter stay in `id_ex_register`.

## Test plan
- **Reset:** assert Reset mid-cycle with EX_Valid=1 and BubbleCount=5 → all outputs 0 immediately, without waiting for Clk.
- **Pass-through:** ID_Valid=1, ID_ImmExt=32'hFFFF8000, ID_Rs=3, ID_Ctrl=12'hABC, no hazard → next edge EX_ImmExt=32'hFFFF8000, EX_Rs=3, EX_Ctrl=12'hABC, EX_Valid=1.
- **Load-use:** lw into Rt=8 sits in EX, ID instruction has Rs=8 → HazardStall=1; next edge EX_Valid=0, EX_Ctrl=0, BubbleCount=1; HazardStall=0 afterwards and the instruction then loads.
- **No hazard on Rt=0 or unused Rt:** EX lw with Rt=0 and ID Rs=0 → HazardStall=0. EX lw with Rt=9, ID Rt=9, ID_UsesRt=0 → HazardStall=0.
- **Priority:** Stall=1 with a pending hazard → registers and BubbleCount unchanged, HazardStall=0. Flush=1 together with a hazard → one bubble, BubbleCount+1.
- **Saturation:** preload the counter at 16'hFFFE, then force three bubbles → BubbleCount reads FFFF, FFFF, FFFF.
